// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub
// Multi-cycle adder/subtractor. Each call processes WIDTH-bit operands
// DIGIT bits per clock, starting with the least-significant digit. The carry
// between digits is held in a register.
// Subtract is implemented as a + ~b + ~c. In subtract mode, carry_out = 1
// means the operation produced no borrow.
// The result registers change only on the cycle that done is asserted.
module digit_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;          // latched operand A
  logic [WIDTH-1:0] b_r;          // latched B' (B already inverted for subtract)
  logic [WIDTH-1:0] res_r;        // partial result, filled one digit per cycle
  logic [WIDTH-1:0] res_next_s;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [IW-1:0]    base_s;       // bit offset of the current digit
  logic [DIGIT:0]   digit_sum_s;
  logic             last_s;
  logic             ov_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: start only matters in IDLE; RUN ends after the last digit
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode: busy is taken straight from the state flop
  always_comb begin
    busy = 1'b0;
    case (state_r)
      IDLE:    busy = 1'b0;
      RUN:     busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Digit adder: add the current digit of A and B' to the carry, then merge
  // the digit result into the partial result
  always_comb begin
    base_s      = IW'(int'(cnt_r) * DIGIT);
    digit_sum_s = {1'b0, a_r[base_s +: DIGIT]} + {1'b0, b_r[base_s +: DIGIT]}
                + {{DIGIT{1'b0}}, carry_r};
    res_next_s  = res_r;
    res_next_s[base_s +: DIGIT] = digit_sum_s[DIGIT-1:0];
    last_s      = (cnt_r == LAST);
    ov_s        = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
  end

  // Datapath registers: latch operands on start, step one digit per RUN cycle,
  // and publish results together with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      res_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      done      <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub ? ~c : c;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          res_r   <= res_next_s;
          carry_r <= digit_sum_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            sum       <= res_next_s;
            carry_out <= digit_sum_s[DIGIT];
            overflow  <= ov_s;
            done      <= 1'b1;
          end else begin
            done      <= 1'b0;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub
// Directed checks on a 16/4 instance, plus a random sweep on four parameter
// sets that is compared against an integer reference model.
module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = 16'h0;
  logic [15:0] b = 16'h0;
  logic        c = 1'b0;
  logic        busy, done, carry_out, overflow;
  logic [15:0] sum;

  logic        sw_start = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_c = 1'b0;
  logic [31:0] sw_a = 32'h0;
  logic [31:0] sw_b = 32'h0;
  logic        bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
  logic        co0, co1, co2, co3, ov0, ov1, ov2, ov3;
  logic [15:0] s0, s1;
  logic [31:0] s2;
  logic [7:0]  s3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out), .overflow(overflow));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u16_16 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[15:0]), .b(sw_b[15:0]), .c(sw_c),
    .busy(bz0), .done(dn0), .sum(s0), .carry_out(co0), .overflow(ov0));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u16_1 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[15:0]), .b(sw_b[15:0]), .c(sw_c),
    .busy(bz1), .done(dn1), .sum(s1), .carry_out(co1), .overflow(ov1));

  digit_serial_addsub #(.WIDTH(32), .DIGIT(8)) u32_8 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a), .b(sw_b), .c(sw_c),
    .busy(bz2), .done(dn2), .sum(s2), .carry_out(co2), .overflow(ov2));

  digit_serial_addsub #(.WIDTH(8), .DIGIT(2)) u8_2 (
    .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]), .c(sw_c),
    .busy(bz3), .done(dn3), .sum(s3), .carry_out(co3), .overflow(ov3));

  // Reference model on plain integers: returns {overflow, carry_out, sum}
  function automatic logic [33:0] golden(input int w, input logic [31:0] ta, input logic [31:0] tb_,
                                         input logic ts, input logic tc);
    longint m, ua, ub, lc, sa, sb, tot, st, hi, lo;
    logic co, ov;
    logic [31:0] s;
    m  = (longint'(1) << w) - 1;
    ua = longint'(ta) & m;
    ub = longint'(tb_) & m;
    lc = tc ? 64'sd1 : 64'sd0;
    sa = ua[w-1] ? ua - (m + 1) : ua;
    sb = ub[w-1] ? ub - (m + 1) : ub;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    if (!ts) begin
      tot = ua + ub + lc;
      co  = (tot > m);
      st  = sa + sb + lc;
    end else begin
      tot = ua - ub - lc;
      co  = (ua >= ub + lc);
      st  = sa - sb - lc;
    end
    s  = 32'(tot & m);
    ov = (st > hi) || (st < lo);
    return {ov, co, s};
  endfunction

  // Issue one operation on the 16/4 instance and wait (bounded) for done
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts, input logic tc,
                       output int lat, output logic [15:0] rs, output logic rco, output logic rov);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; c = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = sum; rco = carry_out; rov = overflow;
  endtask

  task automatic test_reset;
    int lat, seen;
    logic [15:0] rs;
    logic rco, rov;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, carry_out, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got %h exp 00000", {busy, done, sum, carry_out, overflow});
    end
    rst = 1'b0;
    do_op(16'hAAAA, 16'h1111, 1'b0, 1'b0, lat, rs, rco, rov);
    checks++;
    if (rs !== 16'hBBBB) begin
      errors++;
      $display("FAIL reset_preload got %h exp BBBB", rs);
    end
    // abort two cycles into RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; c = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, sum, carry_out, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL reset_midrun got %h exp 00000", {busy, done, sum, carry_out, overflow});
    end
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_resume got %0d active cycles exp 0", seen);
    end
    do_op(16'h0003, 16'h0002, 1'b0, 1'b0, lat, rs, rco, rov);
    checks++;
    if (rs !== 16'h0005 || lat !== 4) begin
      errors++;
      $display("FAIL reset_after got sum %h lat %0d exp 0005 lat 4", rs, lat);
    end
  endtask

  task automatic test_arith;
    logic [15:0] va [7];
    logic [15:0] vb [7];
    logic        vs [7];
    logic        vc [7];
    logic [15:0] es [7];
    logic        eco [7];
    logic        eov [7];
    int lat;
    logic [15:0] rs;
    logic rco, rov;
    va  = '{16'h0003, 16'hFFFF, 16'h7FFF, 16'h00FF, 16'h0005, 16'h8000, 16'h0010};
    vb  = '{16'h0002, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
    vs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    es  = '{16'h0005, 16'h0000, 16'h8000, 16'h0100, 16'hFFFE, 16'h7FFF, 16'h000E};
    eco = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    eov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], vs[i], vc[i], lat, rs, rco, rov);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL arith[%0d] latency got %0d exp 4", i, lat);
      end
      checks++;
      if ({rs, rco, rov} !== {es[i], eco[i], eov[i]}) begin
        errors++;
        $display("FAIL arith[%0d] got sum %h co %b ov %b exp sum %h co %b ov %b",
                 i, rs, rco, rov, es[i], eco[i], eov[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; c = 1'b0; start = 1'b1;
    @(negedge clk);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      start = 1'b1;
      a = 16'($urandom); b = 16'($urandom); sub = ~sub; c = ~c;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== 4 || {sum, carry_out, overflow} !== {16'h2345, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL start_ignored got lat %0d sum %h co %b ov %b exp lat 4 sum 2345 co 0 ov 0",
               lat, sum, carry_out, overflow);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_idle got busy %b done %b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [15:0] rs;
    logic rco, rov;
    do_op(16'h0003, 16'h0002, 1'b0, 1'b0, lat, rs, rco, rov);
    a = 16'h0100; b = 16'h0001; sub = 1'b1; c = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got busy %b done %b exp 1 0", busy, done);
    end
    @(negedge clk);
    checks++;
    if (sum !== 16'h0005) begin
      errors++;
      $display("FAIL b2b_hold got %h exp 0005", sum);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4 || {sum, carry_out, overflow} !== {16'h00FF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second got lat %0d sum %h co %b ov %b exp lat 4 sum 00FF co 1 ov 0",
               lat, sum, carry_out, overflow);
    end
  endtask

  task automatic test_sweep;
    int wv [4];
    int nd [4];
    logic [33:0] exp_r [4];
    logic        odn;
    logic [33:0] obs;
    wv = '{16, 16, 32, 8};
    nd = '{1, 16, 4, 4};
    for (int op = 0; op < 1000; op++) begin
      @(negedge clk);
      sw_a = $urandom; sw_b = $urandom;
      sw_sub = 1'($urandom_range(0, 1)); sw_c = 1'($urandom_range(0, 1));
      sw_start = 1'b1;
      for (int i = 0; i < 4; i++) exp_r[i] = golden(wv[i], sw_a, sw_b, sw_sub, sw_c);
      @(negedge clk);
      sw_start = 1'b0;
      for (int t = 1; t <= 16; t++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          case (i)
            0:       begin odn = dn0; obs = {ov0, co0, 16'h0, s0}; end
            1:       begin odn = dn1; obs = {ov1, co1, 16'h0, s1}; end
            2:       begin odn = dn2; obs = {ov2, co2, s2}; end
            default: begin odn = dn3; obs = {ov3, co3, 24'h0, s3}; end
          endcase
          checks++;
          if (odn !== (t == nd[i])) begin
            errors++;
            if (errors < 40) $display("FAIL sweep%0d op %0d done at t=%0d got %b exp %b",
                                      i, op, t, odn, (t == nd[i]));
          end
          if (t == nd[i]) begin
            checks++;
            if (obs !== exp_r[i]) begin
              errors++;
              if (errors < 40) $display("FAIL sweep%0d op %0d got %h exp %h", i, op, obs, exp_r[i]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_start_ignored();
    test_back_to_back();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first, through a registered carry. It generalises the 4-bit combinational ripple-carry adder with:
- selectable subtract mode and chainable carry/borrow-in;
- signed-overflow detection;
- a start/busy/done handshake.

It sits in the datapath wherever a wide add/sub is needed and area matters more than latency.

## Interface
Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; accepted only when idle.
- sub  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- c  input  1  carry-in (add) or borrow-in (sub); sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- sum  output  WIDTH  result.
- carry_out  output  1  carry-out (add) or NOT borrow-out (sub).
- overflow  output  1  two's-complement signed overflow of the result.

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at a clock edge latches a, b XOR {WIDTH{sub}}, and initial carry = sub ? ~c : c.
  - Clears the digit counter and goes to RUN.
  - start=0 keeps the FSM in IDLE.
- RUN, every edge:
  - Adds digit k of A and B' plus the carry register.
  - Writes the DIGIT result bits into the internal result shift/partial register.
  - Updates the carry register and increments k.
- On the edge processing digit NDIG-1:
  - sum, carry_out and overflow are registered.
  - done is set for one cycle.
  - The FSM returns to IDLE.
- Arithmetic:
  - Add computes a + b + c.
  - Sub computes a − b − c as a + ~b + ~c.
  - carry_out is the final carry (in sub, 1 means no borrow, i.e. a ≥ b + c unsigned).
  - overflow = (A[WIDTH-1] == B'[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]).
- start while busy=1 is ignored; latched operands are unaffected by input changes during RUN.
- sum, carry_out and overflow hold their last value until the next done; they do not change during RUN.
- Reset values: busy=0, done=0, sum=0, carry_out=0, overflow=0; state IDLE; counter and carry register 0.
- rst=1 at any edge, including mid-RUN or during done, aborts the operation; outputs take their reset values on that edge.

## Timing
- Start accepted at edge E0: busy=1 from E0 until edge E0+NDIG.
- At E0+NDIG: busy=0, done=1, results valid.
- At E0+NDIG+1: done=0 unless a new operation completes.
- Latency: NDIG cycles from accepting edge to done.
- Throughput: one operation per NDIG cycles, achieved by back-to-back issue. The done cycle is an IDLE cycle, so start=1 during done is accepted at the next edge.
- DIGIT=WIDTH degenerates to a 1-cycle registered add/sub (done one cycle after start).
- No combinational path from inputs to outputs.

## Test plan
Defaults WIDTH=16, DIGIT=4 (NDIG=4) unless stated.
- Reset: assert rst two cycles into RUN of 0x1234+0x1111 → on that edge busy=0, done=0, sum=0x0000, carry_out=0, overflow=0. A following start of 0x0003+0x0002, c=0 completes normally → sum=0x0005.
- Add:
  - 0x0003+0x0002, c=0 → done exactly 4 edges after start, sum=0x0005, co=0, ov=0.
  - 0xFFFF+0x0001, c=0 → sum=0x0000, co=1, ov=0.
  - 0x7FFF+0x0001, c=0 → sum=0x8000, co=0, ov=1.
  - 0x00FF+0x0000, c=1 → sum=0x0100.
- Sub:
  - 0x0005−0x0007, c=0 → sum=0xFFFE, co=0, ov=0.
  - 0x8000−0x0001, c=0 → sum=0x7FFF, co=1, ov=1.
  - 0x0010−0x0001, c=1 → sum=0x000E, co=1.
- Handshake:
  - start pulsed every cycle during RUN → ignored; the first result is unchanged.
  - start asserted in the done cycle → second operation accepted; second done 4 cycles later.
  - Inputs toggled mid-RUN → result unaffected.
- Parameter sweep: (WIDTH,DIGIT) = (16,16), (16,1), (32,8), (8,2). 1000 random operations each with random sub and c, checked against a golden model on sum, carry_out and overflow, with done latency = NDIG.
